// File: rtl/calfifo_pkg.sv
// calfifo_pkg: shared defaults and threshold helpers for the calibrator FIFO core.
`define CALFIFO_PTR_W(aw) ((aw) + 1)
package calfifo_pkg;
  localparam int WIDTH_DEF     = 18;
  localparam int ADDR_W_DEF    = 10;
  localparam int AEMPTY_TH_DEF = 4;
  localparam int PTR_W_DEF     = `CALFIFO_PTR_W(ADDR_W_DEF);
  function automatic int afull_th(input int aw);
    return (1 << aw) - 4;
  endfunction
endpackage

// File: rtl/calfifo_sync_ram.sv
// calfifo_sync_ram: simple dual-port RAM, one write port and a registered read port.
module calfifo_sync_ram #(
  parameter int WIDTH  = 18,
  parameter int ADDR_W = 10
) (
  input  logic              pos_rclk,
  input  logic              aresetn_rclk,
  input  logic              sresetn_rclk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [2**ADDR_W];
  logic [WIDTH-1:0] r_rdata;
  always_ff @(posedge pos_rclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  // Only the output register is reset; the array itself keeps stale contents.
  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) r_rdata <= '0;
    else if (!sresetn_rclk) r_rdata <= '0;
    else if (i_ren) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/calfifo_sync_core.sv
// calfifo_sync_core: single-clock FIFO core, pointer/count/flag control around a latency-1 RAM.
module calfifo_sync_core
  import calfifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AFULL_TH  = afull_th(ADDR_W),
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic              pos_rclk,
  input  logic              aresetn_rclk,
  input  logic              sresetn_rclk,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  output logic              full,
  output logic              afull,
  output logic              wr_ack,
  output logic              overflow,
  input  logic              fifo_rd_en,
  output logic [WIDTH-1:0]  fifo_dout,
  output logic              fifo_empty,
  output logic              fifo_aempty,
  output logic              underflow,
  output logic [ADDR_W-1:0] fifo_MEMRADDR,
  output logic [ADDR_W:0]   count
);
  localparam int PW = `CALFIFO_PTR_W(ADDR_W);
  localparam logic [PW-1:0] LP_DEPTH  = PW'(1 << ADDR_W);
  localparam logic [PW-1:0] LP_AFULL  = PW'(AFULL_TH);
  localparam logic [PW-1:0] LP_AEMPTY = PW'(AEMPTY_TH);
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count, w_count_next;
  logic r_full, r_afull, r_empty, r_aempty, r_wr_ack, r_overflow, r_underflow;
  logic w_clr, w_we_ok, w_re_ok;
  // A write at full still goes through when a read frees a slot in the same cycle.
  always_comb begin
    w_clr        = ~sresetn_rclk;
    w_re_ok      = fifo_rd_en & ~r_empty;
    w_we_ok      = wr_en & (~r_full | w_re_ok);
    w_count_next = w_clr ? '0 : r_count + PW'(w_we_ok) - PW'(w_re_ok);
  end
  always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
    if (!aresetn_rclk) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_clr ? '0 : r_wr_ptr + PW'(w_we_ok);
      r_rd_ptr    <= w_clr ? '0 : r_rd_ptr + PW'(w_re_ok);
      r_count     <= w_count_next;
      r_full      <= w_count_next == LP_DEPTH;
      r_afull     <= w_count_next >= LP_AFULL;
      r_empty     <= w_count_next == '0;
      r_aempty    <= w_count_next <= LP_AEMPTY;
      r_wr_ack    <= ~w_clr & w_we_ok;
      r_overflow  <= ~w_clr & wr_en & ~w_we_ok;
      r_underflow <= ~w_clr & fifo_rd_en & ~w_re_ok;
    end
  end
  calfifo_sync_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
    .pos_rclk    (pos_rclk),
    .aresetn_rclk(aresetn_rclk),
    .sresetn_rclk(sresetn_rclk),
    .i_we        (w_we_ok & ~w_clr),
    .i_waddr     (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata     (din),
    .i_ren       (w_re_ok),
    .i_raddr     (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata     (fifo_dout)
  );
  assign full          = r_full;
  assign afull         = r_afull;
  assign wr_ack        = r_wr_ack;
  assign overflow      = r_overflow;
  assign fifo_empty    = r_empty;
  assign fifo_aempty   = r_aempty;
  assign underflow     = r_underflow;
  assign fifo_MEMRADDR = r_rd_ptr[ADDR_W-1:0];
  assign count         = r_count;
  ap_count: assert property (@(posedge pos_rclk) disable iff (!aresetn_rclk)
    r_count == r_wr_ptr - r_rd_ptr);
endmodule

// File: tb/tb_calfifo_sync_core.sv
// tb_calfifo_sync_core: scoreboard bench for the FIFO core at WIDTH=8, ADDR_W=4.
module tb_calfifo_sync_core;
  logic       pos_rclk = 0, aresetn_rclk = 0, sresetn_rclk = 1;
  logic       wr_en = 0, fifo_rd_en = 0;
  logic [7:0] din = 0;
  logic       full, afull, wr_ack, overflow, fifo_empty, fifo_aempty, underflow;
  logic [7:0] fifo_dout;
  logic [3:0] fifo_MEMRADDR;
  logic [4:0] count;
  calfifo_sync_core #(.WIDTH(8), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
    .pos_rclk(pos_rclk), .aresetn_rclk(aresetn_rclk), .sresetn_rclk(sresetn_rclk),
    .wr_en(wr_en), .din(din), .full(full), .afull(afull), .wr_ack(wr_ack),
    .overflow(overflow), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty), .underflow(underflow),
    .fifo_MEMRADDR(fifo_MEMRADDR), .count(count)
  );
  always #5 pos_rclk = ~pos_rclk;
  int         total = 0, bad = 0, mcount = 0;
  logic [7:0] mq[$], exp_q[$];
  logic [3:0] mrptr = 0;
  logic       e_ack = 0, e_ovf = 0, e_udf = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic check_state();
    chk("count", 32'(count), 32'(mcount));
    chk("empty", 32'(fifo_empty), 32'(mcount == 0));
    chk("full", 32'(full), 32'(mcount == 16));
    chk("afull", 32'(afull), 32'(mcount >= 12));
    chk("aempty", 32'(fifo_aempty), 32'(mcount <= 4));
    chk("memraddr", 32'(fifo_MEMRADDR), 32'(mrptr));
    chk("wr_ack", 32'(wr_ack), 32'(e_ack));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("underflow", 32'(underflow), 32'(e_udf));
  endtask
  task automatic model_clear();
    mcount = 0; mq.delete(); exp_q.delete(); mrptr = 0;
    e_ack = 0; e_ovf = 0; e_udf = 0;
  endtask
  task automatic step(input logic we, input logic [7:0] d, input logic re);
    logic rok, wok;
    wr_en = we; din = d; fifo_rd_en = re;
    rok = re && mcount > 0;
    wok = we && (mcount < 16 || rok);
    if (rok) begin exp_q.push_back(mq.pop_front()); mrptr++; end
    if (wok) mq.push_back(d);
    mcount += int'(wok) - int'(rok);
    e_ack = wok; e_ovf = we && !wok; e_udf = re && !rok;
    @(posedge pos_rclk); #1;
    check_state();
  endtask
  // Read-data monitor: every accepted read yields one fifo_dout compare a cycle later.
  initial begin
    logic pend;
    forever begin
      @(posedge pos_rclk);
      pend = fifo_rd_en && !fifo_empty && aresetn_rclk && sresetn_rclk;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dout: got %0h expected nothing (scoreboard empty)", fifo_dout);
        end else chk("dout", 32'(fifo_dout), 32'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    int nw;
    repeat (2) @(posedge pos_rclk);
    #1;
    check_state();
    chk("reset_dout", 32'(fifo_dout), 0);
    aresetn_rclk = 1;
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'hFF, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    step(0, 0, 1);
    step(1, 8'h33, 1);
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0);
    step(1, 8'hA5, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1);
    nw = 0;
    for (int k = 0; k < 400 && (nw < 40 || mcount > 0); k++) begin
      logic we, re;
      we = nw < 40 && $urandom_range(0, 2) != 0;
      re = nw >= 40 || $urandom_range(0, 1) == 1;
      step(we, 8'(8'h40 + nw), re);
      if (we) nw++;
    end
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), i == 2);
    step(0, 0, 0);
    #2;
    aresetn_rclk = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(fifo_empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_dout", 32'(fifo_dout), 0);
    chk("arst_memraddr", 32'(fifo_MEMRADDR), 0);
    model_clear();
    @(posedge pos_rclk); #1;
    aresetn_rclk = 1;
    step(1, 8'h5A, 0);
    step(1, 8'h6B, 1);
    sresetn_rclk = 0; wr_en = 1; din = 8'hEE; fifo_rd_en = 0;
    @(posedge pos_rclk); #1;
    model_clear();
    check_state();
    chk("srst_dout", 32'(fifo_dout), 0);
    sresetn_rclk = 1;
    step(1, 8'h77, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
